// File: rtl/iccm_prog_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iccm_prog_arbiter
// Purpose  : Arbitrates the single ICCM port between the SPI program loader
//            and the core instruction fetch. While programming (BOOT/DRAIN)
//            the loader's writes are buffered and streamed into the ICCM one
//            per cycle and the core is held in reset. Once the loader flags
//            completion and the buffer is drained, the core is released and
//            owns the port for fetches (RUN).
// Ports    :
//   clk_i, rst_i         clock, asynchronous active-high reset
//   prog_waddr_i/wdata_i loader write word address / data
//   prog_wvalid_i        loader write strobe (level; one push per rising edge)
//   prog_done_i          loader end-of-program flag (level)
//   core_req_i/addr_i    core fetch request / word address
//   core_gnt_o           fetch accepted this cycle
//   core_rvalid_o/rdata_o fetch data, one cycle after grant
//   core_rst_o           active-high reset to the core
//   mem_*                ICCM single-port SRAM interface (csb active-low)
//   word_cnt_o           number of words written into the ICCM (saturating)
//   overflow_o           sticky: a loader write was dropped (buffer full)
// Revision : 1.0 - initial release
// ============================================================================
module iccm_prog_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] prog_waddr_i,
    input  logic [31:0]           prog_wdata_i,
    input  logic                  prog_wvalid_i,
    input  logic                  prog_done_i,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    output logic                  core_rst_o,
    output logic                  mem_csb_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    output logic [ADDR_WIDTH:0]   word_cnt_o,
    output logic                  overflow_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_wv;       // previous prog_wvalid_i
    logic                  r_done;     // previous prog_done_i
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [31:0]           r_fifo_data [FIFO_DEPTH];
    logic                  r_rvalid;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic                  r_overflow;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_push_evt;
    logic       w_done_rise;
    logic       w_prog_phase;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push_ok;
    logic       w_push_drop;
    logic       w_gnt;

    always_comb begin
        // A held strobe must produce one push, so only its rising edge counts.
        w_push_evt   = prog_wvalid_i & ~r_wv;
        w_done_rise  = prog_done_i & ~r_done;
        w_prog_phase = (r_state != c_ST_RUN);
        w_empty      = (r_count == '0);
        w_full       = (r_count == c_FULL);
        // The ICCM port is free while programming, so the head drains every
        // cycle the buffer holds something.
        w_pop        = w_prog_phase & ~w_empty;
        // A full buffer can still take a word if the head leaves this cycle.
        w_push_ok    = w_prog_phase & w_push_evt & (~w_full | w_pop);
        // Writes arriving after the core is released are ignored silently;
        // only programming-phase drops are reported as overflow.
        w_push_drop  = w_prog_phase & w_push_evt & w_full & ~w_pop;
        w_gnt        = (r_state == c_ST_RUN) & core_req_i;
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_BOOT: begin
                if (w_done_rise) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // A push in this cycle lands in the buffer and must still be
                // written, so hold DRAIN until a quiet empty cycle.
                if (w_empty && !w_push_evt) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_state_nxt = c_ST_RUN;
            end
            default: begin
                w_state_nxt = c_ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Edge detectors
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wv   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_wv   <= prog_wvalid_i;
            r_done <= prog_done_i;
        end
    end

    // ------------------------------------------------------------------------
    // Write buffer: pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_fifo_addr[r_wptr] <= prog_waddr_i;
            r_fifo_data[r_wptr] <= prog_wdata_i;
        end
    end

    // ------------------------------------------------------------------------
    // Status counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop && (r_word_cnt != '1)) begin
                r_word_cnt <= r_word_cnt + (ADDR_WIDTH + 1)'(1);
            end
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fetch response: SRAM data arrives one cycle after the read
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
        end
    end

    // ------------------------------------------------------------------------
    // ICCM port mux: programming writes and fetches are mutually exclusive
    // by state, so a simple priority mux suffices.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_csb_o   = 1'b1;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_pop) begin
            mem_csb_o   = 1'b0;
            mem_we_o    = 1'b1;
            mem_addr_o  = r_fifo_addr[r_rptr];
            mem_wdata_o = r_fifo_data[r_rptr];
        end else if (w_gnt) begin
            mem_csb_o   = 1'b0;
            mem_addr_o  = core_addr_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign core_gnt_o    = w_gnt;
    assign core_rvalid_o = r_rvalid;
    assign core_rdata_o  = r_rvalid ? mem_rdata_i : 32'h0;
    // Decoded straight from the state register, so it is glitch-free.
    assign core_rst_o    = w_prog_phase;
    assign word_cnt_o    = r_word_cnt;
    assign overflow_o    = r_overflow;

endmodule
`default_nettype wire

// File: doc/iccm_prog_arbiter.md
ICCM_PROG_ARBITER -- requirements
Module: iccm_prog_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: ICCM word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: programming write buffer depth, power of two.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning).
- clk_i  in  1  sole clock; one clock; all logic on posedge clk_i.
- rst_i  in  1  reset, asynchronous and active-high.
- prog_waddr_i  in  ADDR_WIDTH  SPI-loader write word address.
- prog_wdata_i  in  32  SPI-loader write data, byte-swapped already.
- prog_wvalid_i  in  1  SPI-loader write strobe; level, may stay high several cycles.
- prog_done_i  in  1  SPI-loader end-of-program flag; level.
- core_req_i  in  1  core fetch request.
- core_addr_i  in  ADDR_WIDTH  core fetch word address.
- core_gnt_o  out  1  fetch granted this cycle.
- core_rvalid_o  out  1  fetch data valid.
- core_rdata_o  out  32  fetch data.
- core_rst_o  out  1  active-high reset to core.
- mem_csb_o  out  1  ICCM chip select, active-low.
- mem_we_o  out  1  ICCM write enable.
- mem_addr_o  out  ADDR_WIDTH  ICCM address.
- mem_wdata_o  out  32  ICCM write data.
- mem_rdata_i  in  32  ICCM read data, valid one cycle after a read.
- word_cnt_o  out  ADDR_WIDTH+1  words written to ICCM.
- overflow_o  out  1  sticky: a programming write was dropped.

Function
REQ-004 SHALL register prog_wvalid_i once (wv_q); a push event SHALL be prog_wvalid_i & ~wv_q (rising edge); a level held N cycles SHALL yield exactly one push.
REQ-005 SHALL buffer {prog_waddr_i, prog_wdata_i} sampled in the push-event cycle into a FIFO_DEPTH-entry FIFO with wrapping read/write pointers and an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-006 A push SHALL be accepted when not full, or when full with a pop in the same cycle; otherwise it SHALL be dropped and overflow_o SHALL be set until reset.
REQ-007 SHALL implement states BOOT, DRAIN and RUN; the reset state SHALL be BOOT.
REQ-008 In BOOT and DRAIN, each cycle the FIFO is non-empty SHALL pop the head and drive mem_csb_o=0, mem_we_o=1, mem_addr_o/mem_wdata_o=head, combinationally, in the same cycle (one write per cycle).
REQ-009 Each ICCM write SHALL increment word_cnt_o by 1, saturating at all-ones.
REQ-010 BOOT->DRAIN SHALL occur on the first cycle with prog_done_i=1, detected as a rising edge of prog_done_i.
REQ-011 DRAIN SHALL still accept push events, and SHALL go to RUN on the first cycle with FIFO empty and no push event.
REQ-012 In RUN, push events SHALL be dropped without setting overflow_o, and the FIFO SHALL NOT be written.
REQ-013 core_rst_o SHALL be 1 in BOOT and DRAIN, and SHALL be 0 from the cycle after entry to RUN.
REQ-014 In RUN, core_req_i=1 SHALL give core_gnt_o=1 combinationally in the same cycle, with mem_csb_o=0, mem_we_o=0, mem_addr_o=core_addr_i.
REQ-015 core_rvalid_o SHALL be the one-cycle-delayed core_gnt_o; core_rdata_o SHALL equal mem_rdata_i whenever core_rvalid_o=1, and 0 otherwise.
REQ-016 In BOOT and DRAIN, core_gnt_o SHALL be 0 regardless of core_req_i.
REQ-017 When no access occurs, mem_csb_o SHALL be 1 and mem_we_o, mem_addr_o and mem_wdata_o SHALL be 0.
REQ-018 Simultaneous push event and prog_done_i rise SHALL accept the push and enter DRAIN; that word SHALL be written before RUN.

Reset
REQ-019 While rst_i=1 (asynchronously), the following SHALL hold: state=BOOT, FIFO empty, pointers 0, wv_q=0, core_rst_o=1, core_gnt_o=0, core_rvalid_o=0, core_rdata_o=0, mem_csb_o=1, mem_we_o=0, word_cnt_o=0, overflow_o=0.
REQ-020 Reset asserted mid-write or mid-DRAIN SHALL discard all buffered words; after release, operation SHALL restart in BOOT.

Verification
REQ-021 The bench SHALL hold prog_wvalid_i high for 3 cycles with addr 0x005, data 0xDEADBEEF -> exactly one ICCM write 0x005/0xDEADBEEF, word_cnt_o=1.
REQ-022 The bench SHALL make 6 back-to-back push events with the pop path stalled by forced reset mid-sequence -> after release, FIFO empty, word_cnt_o=0, overflow_o=0, core_rst_o=1.
REQ-023 The bench SHALL push 3 words then raise prog_done_i in the same cycle as the 3rd push -> 3 writes, then RUN, with core_rst_o falling one cycle after the last write.
REQ-024 In RUN, the bench SHALL issue core_req_i with addr 0x010 while mem returns 0x00000013 -> core_gnt_o=1 in the same cycle; core_rvalid_o=1 and core_rdata_o=0x00000013 next cycle.
REQ-025 In RUN, the bench SHALL pulse prog_wvalid_i -> no ICCM write, word_cnt_o unchanged, overflow_o=0.
REQ-026 In BOOT, the bench SHALL hold core_req_i=1 for 10 cycles -> core_gnt_o=0 throughout, with mem_csb_o=1 except during programming writes.
